exmem_stage: RTL and testbench

- Next-generation EX/MEM pipeline register for the RV64I core, with a valid/ready handshake in place of a bare stall.
- Resolves branches and jumps locally by comparing the operands, rather than inferring the outcome from the ALU result.
- Computes the resolved next PC and the link value, and detects mispredictions against the fetch-predicted PC.
- Raises a one-cycle redirect to fetch and a misaligned-target exception flag.

---
 rtl/core_pkg.sv | 23 ++
 rtl/branch_cmp.sv | 27 ++
 rtl/exmem_stage.sv | 124 ++++++++++++
 tb/tb_exmem_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV64I core constants: branch types, memory widths, PC steps.
// Imported by pipeline stages and reusable compare units.
package core_pkg;

  localparam logic [2:0] B_EQ  = 3'b000;
  localparam logic [2:0] B_NE  = 3'b001;
  localparam logic [2:0] B_LT  = 3'b100;
  localparam logic [2:0] B_GE  = 3'b101;
  localparam logic [2:0] B_LTU = 3'b110;
  localparam logic [2:0] B_GEU = 3'b111;

  localparam logic [2:0] MW_B  = 3'b000;
  localparam logic [2:0] MW_H  = 3'b001;
  localparam logic [2:0] MW_W  = 3'b010;
  localparam logic [2:0] MW_D  = 3'b011;
  localparam logic [2:0] MW_BU = 3'b100;
  localparam logic [2:0] MW_HU = 3'b101;
  localparam logic [2:0] MW_WU = 3'b110;

  localparam int STEP_RVI = 4;
  localparam int STEP_RVC = 2;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition from two operands and funct3.
// Reserved types 010/011 resolve as not-taken.
module branch_cmp
  import core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      brty,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (brty)
      B_EQ:    taken = (rs1 == rs2);
      B_NE:    taken = (rs1 != rs2);
      B_LT:    taken = ($signed(rs1) < $signed(rs2));
      B_GE:    taken = ($signed(rs1) >= $signed(rs2));
      B_LTU:   taken = (rs1 < rs2);
      B_GEU:   taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, local branch
// resolution, misprediction redirect and misaligned-target flag.
module exmem_stage
  import core_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int RF_SIZE = 5,
  parameter int C_EXT   = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               flush_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    pred_pc_i,
  input  logic               rvc_i,
  input  logic               isbr_i,
  input  logic               isjal_i,
  input  logic               isjalr_i,
  input  logic [2:0]         brty_i,
  input  logic [XLEN-1:0]    rs1_i,
  input  logic [XLEN-1:0]    rs2_i,
  input  logic [XLEN-1:0]    imme_i,
  input  logic [XLEN-1:0]    alures_i,
  input  logic               erd_i,
  input  logic [RF_SIZE-1:0] rd_i,
  input  logic               ememr_i,
  input  logic               ememw_i,
  input  logic [2:0]         memwid_i,
  input  logic [XLEN-1:0]    memdata_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    pcn_o,
  output logic [XLEN-1:0]    res_o,
  output logic [XLEN-1:0]    memdata_o,
  output logic               erd_o,
  output logic [RF_SIZE-1:0] rd_o,
  output logic               ememr_o,
  output logic               ememw_o,
  output logic [2:0]         memwid_o,
  output logic               excp_o,
  output logic               redirect_o,
  output logic [XLEN-1:0]    redirect_pc_o
);

  localparam logic [XLEN-1:0] ST4 = XLEN'(STEP_RVI);
  localparam logic [XLEN-1:0] ST2 = XLEN'(STEP_RVC);
  localparam logic [XLEN-1:0] LSB = XLEN'(1);

  logic            taken;
  logic            jump;
  logic            tj;
  logic            misal;
  logic            acc;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pcn;
  logic [XLEN-1:0] res;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1   (rs1_i),
    .rs2   (rs2_i),
    .brty  (brty_i),
    .taken (taken)
  );

  assign step     = ((C_EXT != 0) && rvc_i) ? ST2 : ST4;
  assign link     = pc_i + step;
  assign jump     = isjal_i | isjalr_i;
  assign tj       = jump | (isbr_i & taken);
  assign jalr_tgt = (rs1_i + imme_i) & ~LSB;
  assign target   = isjalr_i ? jalr_tgt : pc_i + imme_i;
  assign pcn      = tj ? target : link;
  assign res      = jump ? link : alures_i;
  // with compressed support every even target is legal
  assign misal    = tj & (C_EXT == 0) & target[1];

  assign ready_o  = !rst_i & (!valid_o | ready_i);
  assign acc      = valid_i & ready_o & !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o       <= 1'b0;
      pc_o          <= '0;
      pcn_o         <= '0;
      res_o         <= '0;
      memdata_o     <= '0;
      erd_o         <= 1'b0;
      rd_o          <= '0;
      ememr_o       <= 1'b0;
      ememw_o       <= 1'b0;
      memwid_o      <= '0;
      excp_o        <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else if (flush_i) begin
      valid_o    <= 1'b0;
      excp_o     <= 1'b0;
      redirect_o <= 1'b0;
    end else if (acc) begin
      valid_o       <= 1'b1;
      pc_o          <= pc_i;
      pcn_o         <= pcn;
      res_o         <= res;
      memdata_o     <= memdata_i;
      erd_o         <= erd_i & !misal;
      rd_o          <= rd_i;
      ememr_o       <= ememr_i & !misal;
      ememw_o       <= ememw_i & !misal;
      memwid_o      <= memwid_i;
      excp_o        <= misal;
      redirect_o    <= (pcn != pred_pc_i) & !misal;
      redirect_pc_o <= pcn;
    end else begin
      redirect_o <= 1'b0;
      if (ready_i) valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exmem_stage.sv
// Scoreboard bench for exmem_stage: two instances (C_EXT=0 and 1) share
// stimulus; a reference model predicts each cycle's outputs.
module tb_exmem_stage;

  typedef struct packed {
    logic [63:0] pc, pred;
    logic        rvc, isbr, isjal, isjalr;
    logic [2:0]  brty;
    logic [63:0] rs1, rs2, imm, alu;
    logic        erd;
    logic [4:0]  rd;
    logic        memr, memw;
    logic [2:0]  memwid;
    logic [63:0] mdata;
  } txn_t;

  typedef struct packed {
    logic        valid, redirect, excp;
    logic [63:0] rpc, pc, pcn, res, mdata;
    logic        erd;
    logic [4:0]  rd;
    logic        memr, memw;
    logic [2:0]  memwid;
  } exp_t;

  logic        clk = 0;
  logic        rst_i = 1;
  logic        valid_i = 0, flush_i = 0, ready_i = 0;
  logic [63:0] pc_i = 0, pred_pc_i = 0;
  logic        rvc_i = 0, isbr_i = 0, isjal_i = 0, isjalr_i = 0;
  logic [2:0]  brty_i = 0;
  logic [63:0] rs1_i = 0, rs2_i = 0, imme_i = 0, alures_i = 0;
  logic        erd_i = 0;
  logic [4:0]  rd_i = 0;
  logic        ememr_i = 0, ememw_i = 0;
  logic [2:0]  memwid_i = 0;
  logic [63:0] memdata_i = 0;

  logic        rdyo[2], vo[2], erdo[2], mro[2], mwo[2], exo[2], rdro[2];
  logic [63:0] pco[2], pcno[2], reso[2], mdo[2], rpco[2];
  logic [4:0]  rdo[2];
  logic [2:0]  mwido[2];

  int   n_chk = 0;
  int   n_fail = 0;
  bit   in_rst = 1;
  exp_t q0[$], q1[$];
  exp_t cur0 = '0, cur1 = '0;

  always #5 clk = ~clk;

  exmem_stage #(.XLEN(64), .RF_SIZE(5), .C_EXT(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rdyo[0]),
    .flush_i(flush_i), .pc_i(pc_i), .pred_pc_i(pred_pc_i), .rvc_i(rvc_i),
    .isbr_i(isbr_i), .isjal_i(isjal_i), .isjalr_i(isjalr_i),
    .brty_i(brty_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imme_i(imme_i),
    .alures_i(alures_i), .erd_i(erd_i), .rd_i(rd_i), .ememr_i(ememr_i),
    .ememw_i(ememw_i), .memwid_i(memwid_i), .memdata_i(memdata_i),
    .valid_o(vo[0]), .ready_i(ready_i), .pc_o(pco[0]), .pcn_o(pcno[0]),
    .res_o(reso[0]), .memdata_o(mdo[0]), .erd_o(erdo[0]), .rd_o(rdo[0]),
    .ememr_o(mro[0]), .ememw_o(mwo[0]), .memwid_o(mwido[0]),
    .excp_o(exo[0]), .redirect_o(rdro[0]), .redirect_pc_o(rpco[0])
  );

  exmem_stage #(.XLEN(64), .RF_SIZE(5), .C_EXT(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rdyo[1]),
    .flush_i(flush_i), .pc_i(pc_i), .pred_pc_i(pred_pc_i), .rvc_i(rvc_i),
    .isbr_i(isbr_i), .isjal_i(isjal_i), .isjalr_i(isjalr_i),
    .brty_i(brty_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imme_i(imme_i),
    .alures_i(alures_i), .erd_i(erd_i), .rd_i(rd_i), .ememr_i(ememr_i),
    .ememw_i(ememw_i), .memwid_i(memwid_i), .memdata_i(memdata_i),
    .valid_o(vo[1]), .ready_i(ready_i), .pc_o(pco[1]), .pcn_o(pcno[1]),
    .res_o(reso[1]), .memdata_o(mdo[1]), .erd_o(erdo[1]), .rd_o(rdo[1]),
    .ememr_o(mro[1]), .ememw_o(mwo[1]), .memwid_o(mwido[1]),
    .excp_o(exo[1]), .redirect_o(rdro[1]), .redirect_pc_o(rpco[1])
  );

  function automatic exp_t model(txn_t t, bit cext);
    exp_t        e;
    logic [63:0] step, tgt;
    bit          tk, tj, mis;
    step = (cext && t.rvc) ? 64'd2 : 64'd4;
    case (t.brty)
      3'd0: tk = (t.rs1 == t.rs2);
      3'd1: tk = (t.rs1 != t.rs2);
      3'd4: tk = ($signed(t.rs1) < $signed(t.rs2));
      3'd5: tk = ($signed(t.rs1) >= $signed(t.rs2));
      3'd6: tk = (t.rs1 < t.rs2);
      3'd7: tk = (t.rs1 >= t.rs2);
      default: tk = 0;
    endcase
    tj  = t.isjal || t.isjalr || (t.isbr && tk);
    tgt = t.isjalr ? ((t.rs1 + t.imm) & ~64'd1) : (t.pc + t.imm);
    mis = tj && !cext && tgt[1];
    e.valid    = 1;
    e.pc       = t.pc;
    e.pcn      = tj ? tgt : t.pc + step;
    e.res      = (t.isjal || t.isjalr) ? t.pc + step : t.alu;
    e.mdata    = t.mdata;
    e.excp     = mis;
    e.erd      = mis ? 1'b0 : t.erd;
    e.memr     = mis ? 1'b0 : t.memr;
    e.memw     = mis ? 1'b0 : t.memw;
    e.rd       = t.rd;
    e.memwid   = t.memwid;
    e.redirect = (e.pcn != t.pred) && !mis;
    e.rpc      = e.pcn;
    return e;
  endfunction

  function automatic exp_t nxt(exp_t c, txn_t t, bit v, bit fl, bit rdy,
                               bit cext);
    exp_t n;
    n = c;
    if (fl) begin
      n.valid = 0; n.excp = 0; n.redirect = 0;
    end else if (v && (!c.valid || rdy)) begin
      n = model(t, cext);
    end else begin
      n.redirect = 0;
      if (c.valid && rdy) n.valid = 0;
    end
    return n;
  endfunction

  task automatic cmp(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic check(int d, exp_t e);
    string p;
    p = $sformatf("d%0d.", d);
    cmp({p, "valid"}, 64'(vo[d]), 64'(e.valid));
    cmp({p, "ready"}, 64'(rdyo[d]), 64'(!e.valid || ready_i));
    cmp({p, "redirect"}, 64'(rdro[d]), 64'(e.redirect));
    cmp({p, "excp"}, 64'(exo[d]), 64'(e.excp));
    if (e.redirect) cmp({p, "redirect_pc"}, rpco[d], e.rpc);
    if (e.valid) begin
      cmp({p, "pc"}, pco[d], e.pc);
      cmp({p, "pcn"}, pcno[d], e.pcn);
      cmp({p, "res"}, reso[d], e.res);
      cmp({p, "memdata"}, mdo[d], e.mdata);
      cmp({p, "ctl"}, {mwido[d], rdo[d], erdo[d], mro[d], mwo[d]},
          {e.memwid, e.rd, e.erd, e.memr, e.memw});
    end
  endtask

  task automatic zero_chk(string tag);
    for (int d = 0; d < 2; d++) begin
      cmp({tag, "_valid"}, 64'(vo[d]), 0);
      cmp({tag, "_ready"}, 64'(rdyo[d]), 0);
      cmp({tag, "_flags"}, {exo[d], rdro[d], erdo[d], mro[d], mwo[d]}, 0);
      cmp({tag, "_data"}, pco[d] | pcno[d] | reso[d] | mdo[d] | rpco[d], 0);
      cmp({tag, "_ctl"}, {mwido[d], rdo[d]}, 0);
    end
  endtask

  initial begin : monitor
    exp_t e0, e1;
    forever begin
      @(posedge clk);
      if (q0.size() > 0 && q1.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        @(negedge clk);
        if (!in_rst) begin
          check(0, e0);
          check(1, e1);
        end
      end
    end
  end

  task automatic step(txn_t t, bit v, bit fl, bit rdy);
    @(posedge clk);
    #1;
    pc_i = t.pc; pred_pc_i = t.pred; rvc_i = t.rvc;
    isbr_i = t.isbr; isjal_i = t.isjal; isjalr_i = t.isjalr;
    brty_i = t.brty; rs1_i = t.rs1; rs2_i = t.rs2; imme_i = t.imm;
    alures_i = t.alu; erd_i = t.erd; rd_i = t.rd; ememr_i = t.memr;
    ememw_i = t.memw; memwid_i = t.memwid; memdata_i = t.mdata;
    valid_i = v; flush_i = fl; ready_i = rdy;
    cur0 = nxt(cur0, t, v, fl, rdy, 0);
    cur1 = nxt(cur1, t, v, fl, rdy, 1);
    q0.push_back(cur0);
    q1.push_back(cur1);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    valid_i = 0; flush_i = 0; ready_i = 1;
    rst_i = 0;
    in_rst = 0;
  endtask

  function automatic txn_t base(logic [63:0] pc, logic [63:0] pred);
    txn_t t;
    t = '0;
    t.pc = pc; t.pred = pred;
    t.alu = 64'hA5A5_0000_1234_5678;
    t.erd = 1; t.rd = 5'd7; t.mdata = 64'hDEAD_BEEF_0000_0001;
    t.memwid = 3'b011;
    return t;
  endfunction

  function automatic txn_t rnd();
    txn_t t;
    int   k;
    t = '0;
    k = $urandom_range(0, 3);
    t.isbr = (k == 1); t.isjal = (k == 2); t.isjalr = (k == 3);
    t.brty = 3'($urandom);
    t.pc = {32'h0, $urandom} & ~64'd1;
    t.rs1 = {$urandom, $urandom};
    t.rs2 = ($urandom_range(0, 1) == 1) ? t.rs1 : {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) t.rs2 = {1'b1, t.rs1[62:0]};
    t.imm = 64'($signed(13'($urandom))) & ~64'd1;
    t.rvc = 1'($urandom);
    t.alu = {$urandom, $urandom};
    t.erd = 1'($urandom); t.rd = 5'($urandom);
    t.memr = 1'($urandom); t.memw = 1'($urandom);
    t.memwid = 3'($urandom); t.mdata = {$urandom, $urandom};
    t.pred = ($urandom_range(0, 1) == 1) ? model(t, 0).pcn : t.pc + 4;
    return t;
  endfunction

  initial begin : driver
    txn_t t;
    #1;
    zero_chk("reset");
    release_rst();

    t = base(64'h1000, 64'h1004);
    t.isbr = 1; t.brty = 3'b000; t.rs1 = 5; t.rs2 = 5; t.imm = 64'h40;
    step(t, 1, 0, 1);
    step('0, 0, 0, 1);

    t = base(64'h2000, 64'h2080);
    t.isbr = 1; t.brty = 3'b100; t.rs1 = '1; t.rs2 = 1; t.imm = 64'h80;
    step(t, 1, 0, 1);
    t.brty = 3'b110; t.pred = 64'h2004;
    step(t, 1, 0, 1);
    t.brty = 3'b010; t.rs1 = 1;
    step(t, 1, 0, 1);

    t = base(64'h100, 64'h104);
    t.isjalr = 1; t.rs1 = 64'h2003; t.memw = 1;
    step(t, 1, 0, 1);
    t = base(64'h100, 64'h120);
    t.isjal = 1; t.imm = 64'h20;
    step(t, 1, 0, 1);

    t = base(64'h300, 64'h304);
    t.isjal = 1; t.imm = 64'h100;
    step(t, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(t, 0, 0, 0);
    t = base(64'h400, 64'h404);
    step(t, 1, 0, 1);
    t = base(64'h404, 64'h999);
    step(t, 1, 0, 1);

    t = base(64'h500, 64'h600);
    step(t, 1, 1, 1);
    step(t, 0, 0, 1);

    t = base(64'h200, 64'h204);
    t.rvc = 1;
    step(t, 1, 0, 1);
    step('0, 0, 0, 1);

    t = base(64'h700, 64'h704);
    t.isbr = 1; t.brty = 3'b001; t.rs1 = 1; t.imm = 64'h10;
    step(t, 1, 0, 1);
    step(t, 0, 0, 0);
    step(t, 0, 0, 0);
    @(posedge clk);
    #3;
    in_rst = 1;
    rst_i = 1;
    #1;
    zero_chk("async_rst");
    q0.delete(); q1.delete();
    cur0 = '0; cur1 = '0;
    release_rst();

    for (int i = 0; i < 600; i++) begin
      t = rnd();
      step(t, $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7);
    end
    step('0, 0, 0, 1);
    step('0, 0, 0, 1);
    repeat (3) @(posedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain got=%0d exp=0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
